reg_array_16x16: RTL and testbench
==================================

# reg_array_16x16

Storage array of the 16-entry × 16-bit register file. It sits directly downstream of the 4-to-16 read and write wordline decoders. It consumes their one-hot wordlines to perform two combinational reads and one clocked write per cycle, with write-to-read bypass and a hardwired-zero R0. It also provides a sticky one-hot violation flag and a sequential 16-cycle dump port used by the testbench and by the halt path.

## Interface
- WIDTH, 16, data width of each register
- NREGS, 16, number of registers; equals wordline width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- SrcWordline1  in  NREGS  one-hot read select, port 1, from read decoder
- SrcWordline2  in  NREGS  one-hot read select, port 2, from read decoder
- DstWordline  in  NREGS  one-hot write select, from write decoder
- WriteReg  in  1  write enable
- DstData  in  WIDTH  write data
- SrcData1  out  WIDTH  read data, port 1 (combinational)
- SrcData2  out  WIDTH  read data, port 2 (combinational)
- OnehotErr  out  1  sticky wordline-violation flag
- DumpStart  in  1  start a full-array dump
- DumpBusy  out  1  dump in progress
- DumpValid  out  1  DumpIdx/DumpData valid this cycle
- DumpIdx  out  4  register index being dumped
- DumpData  out  WIDTH  stored contents of register DumpIdx

## Operation
- Storage: NREGS×WIDTH flops. Row 0 is never written and always reads 0.
- Write: on the rising edge, row k is written with DstData when all of these hold:
  - WriteReg=1
  - DstWordline has exactly one bit set, at position k
  - k≠0
- Write ignored cases:
  - Non-one-hot DstWordline (zero bits or more than one bit): the write is dropped entirely and OnehotErr is set.
  - DstWordline=bit0: the write is silently dropped; no error.
- Read: SrcDataN is the AND-OR of each row masked by its SrcWordlineN bit.
  - Zero wordline → 0.
  - Multi-hot wordline → bitwise OR of the selected rows.
  - Either of these is a violation and sets OnehotErr.
- Bypass: if WriteReg=1, DstWordline is legal one-hot, not bit0, and equal to SrcWordlineN, then SrcDataN=DstData in the same cycle. Bypass applies to both ports independently.
- OnehotErr check, every cycle:
  - Set when either SrcWordline is not one-hot.
  - Set when WriteReg=1 and DstWordline is not one-hot.
  - Once set, it stays 1 until reset.
- Dump FSM, states IDLE and DUMP:
  - IDLE→DUMP on an edge where DumpStart=1; DumpIdx is loaded with 0.
  - In DUMP, DumpIdx increments each edge. At DumpIdx=15 the FSM returns to IDLE on the next edge.
  - DumpStart is ignored while in DUMP.
  - DumpBusy=DumpValid=(state==DUMP).
  - DumpData is the stored (un-bypassed) value of row DumpIdx during that cycle. A write to that row in the same cycle shows up only in later reads.
  - Normal reads and writes continue unaffected during a dump.

## Timing
- Reset (asynchronous assert, held low):
  - All rows = 0; state = IDLE; DumpIdx = 0; OnehotErr = 0.
  - DumpBusy, DumpValid, DumpData = 0.
  - SrcDataN follows its combinational definition (0 for any selection).
- Write latency: data written at edge N is visible on reads from the cycle after edge N. Same-cycle reads see it through the bypass.
- Read latency: 0 cycles (combinational from wordlines and array).
- OnehotErr: rises in the cycle after the edge that samples the violation.
- Dump: DumpStart sampled high at edge N → DumpValid high for 16 cycles, N+1 through N+16, with DumpIdx 0..15. Low again after edge N+16.
- Back-to-back dump: DumpStart high in the DumpIdx=15 cycle is ignored. The next dump requires DumpStart to be sampled in IDLE.
- Reset mid-dump: immediate return to IDLE with all outputs at reset values. No partial resumption.

## Test plan
- Reset → all reads of R0–R15 return 0x0000; OnehotErr=0; DumpBusy=0.
- Write R3=0xBEEF (DstWordline=0x0008, WriteReg=1), next cycle SrcWordline1=0x0008 → SrcData1=0xBEEF. Same cycle SrcWordline2=0x0010 → 0x0000.
- Bypass: write R5=0x1234 while SrcWordline1=SrcWordline2=0x0020 → both SrcData=0x1234 in the same cycle. Write to R0 with 0xFFFF → R0 still reads 0x0000; OnehotErr stays 0.
- DstWordline=0x0006 with WriteReg=1, DstData=0xAAAA → R1 and R2 unchanged, OnehotErr=1 next cycle. SrcWordline1=0x0000 after a fresh reset → SrcData1=0, OnehotErr=1.
- Load Rk=0x1000+k for k=1..15, pulse DumpStart → 16 DumpValid cycles with DumpIdx 0..15 and DumpData 0x0000, 0x1001…0x100F. DumpStart re-pulsed at idx 7 has no effect.
- Assert rst_n=0 at DumpIdx=9 → DumpBusy/DumpValid drop immediately; all rows read 0 after reset release.

Source files
------------

// File: rtl/reg_array_16x16_if.sv
// Port bundle for the 16x16 register array: read/write wordlines, data, error flag and dump port.
interface reg_array_16x16_if #(
   parameter int WIDTH = 16,
   parameter int NREGS = 16
);
   logic [NREGS-1:0]         SrcWordline1;
   logic [NREGS-1:0]         SrcWordline2;
   logic [NREGS-1:0]         DstWordline;
   logic                     WriteReg;
   logic [WIDTH-1:0]         DstData;
   logic [WIDTH-1:0]         SrcData1;
   logic [WIDTH-1:0]         SrcData2;
   logic                     OnehotErr;
   logic                     DumpStart;
   logic                     DumpBusy;
   logic                     DumpValid;
   logic [$clog2(NREGS)-1:0] DumpIdx;
   logic [WIDTH-1:0]         DumpData;

   modport master (
      output SrcWordline1, SrcWordline2, DstWordline, WriteReg, DstData, DumpStart,
      input  SrcData1, SrcData2, OnehotErr, DumpBusy, DumpValid, DumpIdx, DumpData
   );

   modport slave (
      input  SrcWordline1, SrcWordline2, DstWordline, WriteReg, DstData, DumpStart,
      output SrcData1, SrcData2, OnehotErr, DumpBusy, DumpValid, DumpIdx, DumpData
   );
endinterface

// File: rtl/reg_array_16x16.sv
// 16x16 register file storage: one-hot wordline reads/writes, write bypass, hardwired R0,
// sticky wordline-violation flag and a sequential full-array dump port.
module reg_array_row #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= '0;
      else if (we) q <= d;
   end
endmodule

module reg_array_16x16 #(
   parameter int WIDTH = 16,
   parameter int NREGS = 16
) (
   input logic               clk,
   input logic               rst_n,
   reg_array_16x16_if.slave  bus
);
   localparam int IW = $clog2(NREGS);

   typedef enum logic {IDLE, DUMP} state_t;

   logic [NREGS-1:0][WIDTH-1:0] rows;
   logic [NREGS-1:0]            we;
   logic                        src1_oh, src2_oh, dst_oh, wr_ok, viol;
   logic [WIDTH-1:0]            rd1, rd2;
   logic                        err_q;
   state_t                      state_q, state_d;
   logic [IW-1:0]               idx_q;

   function automatic logic is_onehot(input logic [NREGS-1:0] v);
      return (v != '0) && ((v & (v - NREGS'(1))) == '0);
   endfunction

   assign src1_oh = is_onehot(bus.SrcWordline1);
   assign src2_oh = is_onehot(bus.SrcWordline2);
   assign dst_oh  = is_onehot(bus.DstWordline);
   // A legal write that actually lands in a row; R0 writes are dropped silently.
   assign wr_ok   = bus.WriteReg && dst_oh && !bus.DstWordline[0];
   assign viol    = !src1_oh || !src2_oh || (bus.WriteReg && !dst_oh);

   assign rows[0] = '0;
   assign we[0]   = 1'b0;

   for (genvar k = 1; k < NREGS; k++) begin : g_row
      assign we[k] = wr_ok && bus.DstWordline[k];
      reg_array_row #(.WIDTH(WIDTH)) u_row (
         .clk   (clk),
         .rst_n (rst_n),
         .we    (we[k]),
         .d     (bus.DstData),
         .q     (rows[k])
      );
   end

   // AND-OR read: zero wordline gives 0, multi-hot gives the OR of the selected rows.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      for (int k = 0; k < NREGS; k++) begin
         rd1 |= rows[k] & {WIDTH{bus.SrcWordline1[k]}};
         rd2 |= rows[k] & {WIDTH{bus.SrcWordline2[k]}};
      end
   end

   assign bus.SrcData1 = (wr_ok && bus.DstWordline == bus.SrcWordline1) ? bus.DstData : rd1;
   assign bus.SrcData2 = (wr_ok && bus.DstWordline == bus.SrcWordline2) ? bus.DstData : rd2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_q | viol;
   end

   assign bus.OnehotErr = err_q;

   // Dump FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= (state_q == DUMP) ? idx_q + IW'(1) : '0;
      end
   end

   // Dump FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.DumpStart) state_d = DUMP;
         DUMP:    if (idx_q == IW'(NREGS - 1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Dump FSM: outputs; DumpData shows the stored row, never the bypass value.
   always_comb begin
      bus.DumpBusy  = (state_q == DUMP);
      bus.DumpValid = (state_q == DUMP);
      bus.DumpIdx   = idx_q;
      bus.DumpData  = (state_q == DUMP) ? rows[idx_q] : '0;
   end
endmodule

// File: tb/tb_reg_array_16x16.sv
// Scoreboard bench for reg_array_16x16: expectations queued at stimulus time, popped at compare.
module tb_reg_array_16x16;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   reg_array_16x16_if #(.WIDTH(16), .NREGS(16)) bus ();

   reg_array_16x16 #(.WIDTH(16), .NREGS(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      string       name;
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      bus.SrcWordline1 = 16'h0002;
      bus.SrcWordline2 = 16'h0002;
      bus.DstWordline  = 16'h0002;
      bus.WriteReg     = 1'b0;
      bus.DstData      = 16'h0000;
      bus.DumpStart    = 1'b0;
   endtask

   task automatic do_reset();
      idle_bus();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wr(input int k, input logic [15:0] d);
      bus.DstWordline = 16'(1) << k;
      bus.DstData     = d;
      bus.WriteReg    = 1'b1;
      tick();
      bus.WriteReg    = 1'b0;
   endtask

   task automatic test_reset();
      idle_bus();
      rst_n = 1'b0;
      #3;
      sb.push_back('{"rst_err", 16'h0000});
      sb.push_back('{"rst_busy", 16'h0000});
      sb.push_back('{"rst_dumpdata", 16'h0000});
      e = sb.pop_front(); total++;
      if (16'(bus.OnehotErr) !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.OnehotErr, e.val); end
      e = sb.pop_front(); total++;
      if (16'({bus.DumpBusy, bus.DumpValid}) !== e.val) begin bad++; $display("FAIL %s got=%b%b want=%h", e.name, bus.DumpBusy, bus.DumpValid, e.val); end
      e = sb.pop_front(); total++;
      if (bus.DumpData !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.DumpData, e.val); end
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         bus.SrcWordline1 = 16'(1) << k;
         bus.SrcWordline2 = 16'(1) << (15 - k);
         #1;
         sb.push_back('{$sformatf("rst_rd1_r%0d", k), 16'h0000});
         sb.push_back('{$sformatf("rst_rd2_r%0d", 15 - k), 16'h0000});
         e = sb.pop_front(); total++;
         if (bus.SrcData1 !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.SrcData1, e.val); end
         e = sb.pop_front(); total++;
         if (bus.SrcData2 !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.SrcData2, e.val); end
      end
      tick();
      sb.push_back('{"rst_err_after", 16'h0000});
      e = sb.pop_front(); total++;
      if (16'(bus.OnehotErr) !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.OnehotErr, e.val); end
   endtask

   task automatic test_write_read();
      do_reset();
      bus.SrcWordline1 = 16'h0002;
      bus.SrcWordline2 = 16'h0004;
      wr(3, 16'hBEEF);
      bus.SrcWordline1 = 16'h0008;
      bus.SrcWordline2 = 16'h0010;
      #1;
      sb.push_back('{"wr_r3", 16'hBEEF});
      sb.push_back('{"wr_r4", 16'h0000});
      e = sb.pop_front(); total++;
      if (bus.SrcData1 !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.SrcData1, e.val); end
      e = sb.pop_front(); total++;
      if (bus.SrcData2 !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.SrcData2, e.val); end
   endtask

   task automatic test_bypass();
      bus.SrcWordline1 = 16'h0020;
      bus.SrcWordline2 = 16'h0020;
      bus.DstWordline  = 16'h0020;
      bus.DstData      = 16'h1234;
      bus.WriteReg     = 1'b1;
      #1;
      sb.push_back('{"byp_p1", 16'h1234});
      sb.push_back('{"byp_p2", 16'h1234});
      e = sb.pop_front(); total++;
      if (bus.SrcData1 !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.SrcData1, e.val); end
      e = sb.pop_front(); total++;
      if (bus.SrcData2 !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.SrcData2, e.val); end
      tick();
      bus.WriteReg = 1'b0;
      bus.SrcWordline2 = 16'h0008;
      #1;
      sb.push_back('{"byp_stored_r5", 16'h1234});
      sb.push_back('{"byp_other_r3", 16'hBEEF});
      e = sb.pop_front(); total++;
      if (bus.SrcData1 !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.SrcData1, e.val); end
      e = sb.pop_front(); total++;
      if (bus.SrcData2 !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.SrcData2, e.val); end
      // R0 write: no bypass, no store, no error
      bus.SrcWordline1 = 16'h0001;
      bus.DstWordline  = 16'h0001;
      bus.DstData      = 16'hFFFF;
      bus.WriteReg     = 1'b1;
      #1;
      sb.push_back('{"r0_same_cycle", 16'h0000});
      e = sb.pop_front(); total++;
      if (bus.SrcData1 !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.SrcData1, e.val); end
      tick();
      bus.WriteReg = 1'b0;
      #1;
      sb.push_back('{"r0_after", 16'h0000});
      sb.push_back('{"r0_err", 16'h0000});
      e = sb.pop_front(); total++;
      if (bus.SrcData1 !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.SrcData1, e.val); end
      e = sb.pop_front(); total++;
      if (16'(bus.OnehotErr) !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.OnehotErr, e.val); end
   endtask

   task automatic test_bad_dst();
      do_reset();
      wr(1, 16'h1111);
      wr(2, 16'h2222);
      bus.SrcWordline1 = 16'h0002;
      bus.SrcWordline2 = 16'h0004;
      bus.DstWordline  = 16'h0006;
      bus.DstData      = 16'hAAAA;
      bus.WriteReg     = 1'b1;
      #1;
      sb.push_back('{"bad_dst_err_before", 16'h0000});
      sb.push_back('{"bad_dst_nobyp", 16'h1111});
      e = sb.pop_front(); total++;
      if (16'(bus.OnehotErr) !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.OnehotErr, e.val); end
      e = sb.pop_front(); total++;
      if (bus.SrcData1 !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.SrcData1, e.val); end
      tick();
      bus.WriteReg = 1'b0;
      #1;
      sb.push_back('{"bad_dst_err", 16'h0001});
      sb.push_back('{"bad_dst_r1", 16'h1111});
      sb.push_back('{"bad_dst_r2", 16'h2222});
      e = sb.pop_front(); total++;
      if (16'(bus.OnehotErr) !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.OnehotErr, e.val); end
      e = sb.pop_front(); total++;
      if (bus.SrcData1 !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.SrcData1, e.val); end
      e = sb.pop_front(); total++;
      if (bus.SrcData2 !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.SrcData2, e.val); end
      tick();
      sb.push_back('{"bad_dst_err_sticky", 16'h0001});
      e = sb.pop_front(); total++;
      if (16'(bus.OnehotErr) !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.OnehotErr, e.val); end
   endtask

   task automatic test_bad_src();
      do_reset();
      wr(1, 16'h00F0);
      wr(2, 16'h0F01);
      bus.SrcWordline1 = 16'h0000;
      bus.SrcWordline2 = 16'h0006;
      #1;
      sb.push_back('{"zero_src", 16'h0000});
      sb.push_back('{"multi_src_or", 16'h0FF1});
      sb.push_back('{"bad_src_err_before", 16'h0000});
      e = sb.pop_front(); total++;
      if (bus.SrcData1 !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.SrcData1, e.val); end
      e = sb.pop_front(); total++;
      if (bus.SrcData2 !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.SrcData2, e.val); end
      e = sb.pop_front(); total++;
      if (16'(bus.OnehotErr) !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.OnehotErr, e.val); end
      tick();
      sb.push_back('{"bad_src_err", 16'h0001});
      e = sb.pop_front(); total++;
      if (16'(bus.OnehotErr) !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.OnehotErr, e.val); end
   endtask

   task automatic test_dump();
      do_reset();
      for (int k = 1; k < 16; k++) wr(k, 16'h1000 + 16'(k));
      bus.DumpStart = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         bus.DumpStart = (i == 7) || (i == 15);
         #1;
         sb.push_back('{$sformatf("dump_valid_%0d", i), 16'h0001});
         sb.push_back('{$sformatf("dump_idx_%0d", i), 16'(i)});
         sb.push_back('{$sformatf("dump_data_%0d", i), (i == 0) ? 16'h0000 : 16'h1000 + 16'(i)});
         e = sb.pop_front(); total++;
         if (16'(bus.DumpValid & bus.DumpBusy) !== e.val) begin bad++; $display("FAIL %s got=%b want=%h", e.name, bus.DumpValid, e.val); end
         e = sb.pop_front(); total++;
         if (16'(bus.DumpIdx) !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.DumpIdx, e.val); end
         e = sb.pop_front(); total++;
         if (bus.DumpData !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.DumpData, e.val); end
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         bus.DumpStart = 1'b0;
         #1;
         sb.push_back('{$sformatf("dump_end_%0d", i), 16'h0000});
         e = sb.pop_front(); total++;
         if (16'({bus.DumpValid, bus.DumpBusy}) !== e.val) begin bad++; $display("FAIL %s got=%b%b want=%h", e.name, bus.DumpValid, bus.DumpBusy, e.val); end
      end
   endtask

   task automatic test_reset_mid_dump();
      bus.DumpStart = 1'b1;
      tick();
      bus.DumpStart = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      sb.push_back('{"mid_idx9", 16'h0009});
      e = sb.pop_front(); total++;
      if (16'(bus.DumpIdx) !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.DumpIdx, e.val); end
      #2;
      rst_n = 1'b0;
      #1;
      sb.push_back('{"mid_rst_busy", 16'h0000});
      sb.push_back('{"mid_rst_idx", 16'h0000});
      e = sb.pop_front(); total++;
      if (16'({bus.DumpBusy, bus.DumpValid}) !== e.val) begin bad++; $display("FAIL %s got=%b%b want=%h", e.name, bus.DumpBusy, bus.DumpValid, e.val); end
      e = sb.pop_front(); total++;
      if (16'(bus.DumpIdx) !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.DumpIdx, e.val); end
      tick();
      rst_n = 1'b1;
      for (int k = 1; k < 16; k++) begin
         bus.SrcWordline1 = 16'(1) << k;
         #1;
         sb.push_back('{$sformatf("mid_rst_r%0d", k), 16'h0000});
         e = sb.pop_front(); total++;
         if (bus.SrcData1 !== e.val) begin bad++; $display("FAIL %s got=%h want=%h", e.name, bus.SrcData1, e.val); end
      end
      tick();
      sb.push_back('{"mid_rst_idle", 16'h0000});
      e = sb.pop_front(); total++;
      if (16'(bus.DumpBusy) !== e.val) begin bad++; $display("FAIL %s got=%b want=%h", e.name, bus.DumpBusy, e.val); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_bad_dst();
      test_bad_src();
      test_dump();
      test_reset_mid_dump();
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d want=0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
